// File: rtl/fifo_uart_tx_if.sv
// Bundle between the FIFO read port, the UART drain stage and its status outputs.
// fifo_empty/fifo_rd_en handshake: a word is popped in exactly the cycle where
// fifo_rd_en=1 (only ever driven while fifo_empty=0); fifo_data holds that word
// from the following cycle on. There is no other flow control.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  byte_done;

    modport master (
        output enable, fifo_empty, fifo_data,
        input  fifo_rd_en, tx, busy, byte_done
    );

    modport slave (
        input  enable, fifo_empty, fifo_data,
        output fifo_rd_en, tx, busy, byte_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame and serializes it as 8N1 / 8E1 UART
// (start bit, LSB first, optional even parity, one stop bit) on a registered tx.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                clk,
    input  logic                rst,
    fifo_uart_tx_if.slave       bus,
    output logic [2:0]          fsm_state
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                state, state_next;
    logic [BW-1:0]         baud, baud_next;
    logic [IW-1:0]         idx, idx_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic                  parity, parity_next;
    logic                  tx_q, tx_next;
    logic                  bit_end;
    logic                  start_read;

    assign bit_end    = (baud == BAUD_LAST);
    // Reset gates the strobe so no word is popped while the stage is held in reset.
    assign start_read = (state == S_IDLE) && bus.enable && !bus.fifo_empty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            baud   <= '0;
            idx    <= '0;
            shift  <= '0;
            parity <= 1'b0;
            tx_q   <= 1'b1;
        end else begin
            state  <= state_next;
            baud   <= baud_next;
            idx    <= idx_next;
            shift  <= shift_next;
            parity <= parity_next;
            tx_q   <= tx_next;
        end
    end

    always_comb begin
        state_next  = state;
        baud_next   = baud;
        idx_next    = idx;
        shift_next  = shift;
        parity_next = parity;
        tx_next     = 1'b1;

        case (state)
            S_IDLE: begin
                if (start_read) state_next = S_WAIT;
            end
            S_WAIT: begin
                shift_next  = bus.fifo_data;
                parity_next = (PARITY_EN != 0) ? ^bus.fifo_data : 1'b0;
                baud_next   = '0;
                idx_next    = '0;
                state_next  = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    idx_next   = '0;
                    state_next = S_DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    idx_next   = idx + 1'b1;
                    if (idx == IDX_LAST)
                        state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = S_STOP;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = S_IDLE;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // tx is derived from the next state so the line changes exactly on state entry.
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = parity_next;
            default:  tx_next = 1'b1;
        endcase
    end

    assign bus.fifo_rd_en = start_read;
    assign bus.tx         = tx_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.byte_done  = (state == S_STOP) && bit_end;
    assign fsm_state      = state;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance without parity (a), one with
// even parity (b), each fed by a small registered-output FIFO model.
module tb_fifo_uart_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fsm_a, fsm_b;
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) if_a ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) if_b ();

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(0)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a), .fsm_state(fsm_a)
    );
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b), .fsm_state(fsm_b)
    );

    // FIFO models: bench writes mem/wr, the read side pops on the strobe edge.
    logic [7:0] mem_a [0:63];
    logic [7:0] mem_b [0:63];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

    assign if_a.fifo_empty = (rd_a == wr_a);
    assign if_b.fifo_empty = (rd_b == wr_b);

    always @(posedge clk) begin
        if (if_a.fifo_rd_en) begin
            if_a.fifo_data <= mem_a[rd_a % 64];
            rd_a <= rd_a + 1;
        end
        if (if_b.fifo_rd_en) begin
            if_b.fifo_data <= mem_b[rd_b % 64];
            rd_b <= rd_b + 1;
        end
    end

    function automatic logic tx_of(input int d);   return d ? if_b.tx : if_a.tx;               endfunction
    function automatic logic busy_of(input int d); return d ? if_b.busy : if_a.busy;           endfunction
    function automatic logic rd_of(input int d);   return d ? if_b.fifo_rd_en : if_a.fifo_rd_en; endfunction
    function automatic logic done_of(input int d); return d ? if_b.byte_done : if_a.byte_done; endfunction

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push_a(input logic [7:0] b);
        mem_a[wr_a % 64] = b;
        wr_a++;
    endtask

    task automatic push_b(input logic [7:0] b);
        mem_b[wr_b % 64] = b;
        wr_b++;
    endtask

    task automatic set_en(input int d, input logic v);
        if (d != 0) if_b.enable = v;
        else        if_a.enable = v;
    endtask

    task automatic wait_strobe(input int d, input int budget, output int at);
        int n;
        n = 0;
        #1;
        while (rd_of(d) !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("strobe_seen", rd_of(d), 1'b1);
        at = cyc;
    endtask

    task automatic idle_check(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_tx", tx_of(d), 1'b1);
            check("idle_rd_en", rd_of(d), 1'b0);
            check("idle_busy", busy_of(d), 1'b0);
        end
    endtask

    // Entered on the strobe cycle. Expected line levels come from the byte value:
    // 16-cycle segments start / 8 data LSB first / [parity] / stop.
    task automatic frame(input int d, input logic [7:0] b, input int par,
                         input int drop_at, input int cut_at);
        int          f_len;
        int          seg;
        logic        exp_tx;
        f_len = ((par >= 0) ? 11 : 10) * 16;
        check("strobe_busy", busy_of(d), 1'b0);
        step();
        check("wait_tx", tx_of(d), 1'b1);
        check("wait_busy", busy_of(d), 1'b1);
        check("wait_rd_en", rd_of(d), 1'b0);
        for (int k = 0; k < f_len; k++) begin
            step();
            seg = k / 16;
            if (seg == 0)                   exp_tx = 1'b0;
            else if (seg <= 8)              exp_tx = b[seg-1];
            else if (seg == 9 && par >= 0)  exp_tx = par[0];
            else                            exp_tx = 1'b1;
            check("frame_tx", tx_of(d), exp_tx);
            check("frame_busy", busy_of(d), 1'b1);
            check("frame_rd_en", rd_of(d), 1'b0);
            // byte_done sits on the last cycle of the stop bit: f_len-1 cycles after tx falls.
            check("frame_byte_done", done_of(d), (k == f_len - 1) ? 1'b1 : 1'b0);
            if (k == drop_at) set_en(d, 1'b0);
            if (k == cut_at) return;
        end
    endtask

    initial begin
        int t, prev;
        rst = 1'b1;
        if_a.enable = 1'b0;
        if_b.enable = 1'b0;
        repeat (3) step();
        check("rst_tx_a", if_a.tx, 1'b1);
        check("rst_busy_a", if_a.busy, 1'b0);
        check("rst_rd_en_a", if_a.fifo_rd_en, 1'b0);
        check("rst_done_a", if_a.byte_done, 1'b0);
        check("rst_state_a", fsm_a, 3'd0);
        check("rst_tx_b", if_b.tx, 1'b1);
        check("rst_busy_b", if_b.busy, 1'b0);
        rst = 1'b0;

        // Enabled with an empty FIFO: nothing happens.
        if_a.enable = 1'b1;
        if_b.enable = 1'b1;
        idle_check(0, 200);

        // Single byte 0x10 then silence.
        push_a(8'h10);
        wait_strobe(0, 10, t);
        frame(0, 8'h10, -1, -1, -1);
        idle_check(0, 30);

        // Burst of eight preloaded bytes: strobes every F+2 = 162 cycles.
        if_a.enable = 1'b0;
        for (int i = 0; i < 8; i++) push_a(8'h10 + 8'(i));
        if_a.enable = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            wait_strobe(0, 400, t);
            if (i > 0) check("burst_spacing", t - prev, 162);
            prev = t;
            frame(0, 8'h10 + 8'(i), -1, -1, -1);
        end
        idle_check(0, 200);
        check("burst_fifo_empty", if_a.fifo_empty, 1'b1);

        // enable dropped mid-frame: 0xA0 completes, 0xA1 stays queued.
        if_a.enable = 1'b0;
        push_a(8'hA0);
        push_a(8'hA1);
        if_a.enable = 1'b1;
        wait_strobe(0, 10, t);
        frame(0, 8'hA0, -1, 80, -1);
        idle_check(0, 40);
        check("a1_still_queued", if_a.fifo_empty, 1'b0);
        if_a.enable = 1'b1;
        #1;
        check("reenable_strobe", if_a.fifo_rd_en, 1'b1);
        wait_strobe(0, 2, t);
        frame(0, 8'hA1, -1, -1, -1);

        // Reset during data bit 3 of 0x5A: byte dropped, 0x3C sent next in full.
        if_a.enable = 1'b0;
        push_a(8'h5A);
        push_a(8'h3C);
        if_a.enable = 1'b1;
        wait_strobe(0, 10, t);
        frame(0, 8'h5A, -1, -1, 69);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_tx", if_a.tx, 1'b1);
        check("midrst_busy", if_a.busy, 1'b0);
        check("midrst_done", if_a.byte_done, 1'b0);
        check("midrst_state", fsm_a, 3'd0);
        wait_strobe(0, 10, t);
        frame(0, 8'h3C, -1, -1, -1);
        idle_check(0, 20);

        // Even parity instance: 0xA5 -> parity 0, 0x13 -> parity 1, frame 176 cycles.
        push_b(8'hA5);
        push_b(8'h13);
        wait_strobe(1, 10, prev);
        frame(1, 8'hA5, 0, -1, -1);
        wait_strobe(1, 10, t);
        check("parity_spacing", t - prev, 178);
        frame(1, 8'h13, 1, -1, -1);
        idle_check(1, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
